// File: rtl/md_sched_if.sv
// Command/result bundle between the EX stage and the HI/LO multiply-divide scheduler.
interface md_sched_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, op, A, B, input busy, md_stall, HI, LO);
    modport slave  (input start, op, A, B, output busy, md_stall, HI, LO);
endinterface

// File: rtl/md_sched.sv
// Fixed-latency mult/div scheduler owning HI/LO; define MD_SCHED_MADD_EN to enable
// the multiply-accumulate ops (op 6 madd, op 7 maddu).
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    md_sched_if.slave   bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]        op_reg, op_next;
    logic [31:0]       a_reg, a_next, b_reg, b_next;
    logic [31:0]       hi_reg, hi_next, lo_reg, lo_next;
    logic              busy_reg, busy_next;

    logic              launch_op;
    logic              start_is_div;
    logic              signed_op;
    logic              op_is_div;
    logic [63:0]       ext_a, ext_b, product;
    logic              a_neg, b_neg;
    logic [31:0]       a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

`ifdef MD_SCHED_MADD_EN
    logic [63:0]       acc;
    assign launch_op = (bus.op <= 3'd3) || (bus.op >= 3'd6);
`else
    assign launch_op = (bus.op <= 3'd3);
`endif
    assign start_is_div = (bus.op[2:1] == 2'b01);

    // Even op codes are the signed variants (mult, div, madd).
    assign signed_op = ~op_reg[0];
    assign op_is_div = (op_reg[2:1] == 2'b01);

    assign ext_a   = {{32{signed_op & a_reg[31]}}, a_reg};
    assign ext_b   = {{32{signed_op & b_reg[31]}}, b_reg};
    assign product = ext_a * ext_b;

    // Divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000, rem 0.
    assign a_neg   = signed_op & a_reg[31];
    assign b_neg   = signed_op & b_reg[31];
    assign a_mag   = a_neg ? -a_reg : a_reg;
    assign b_mag   = b_neg ? -b_reg : b_reg;
    assign divisor = (b_reg == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / divisor;
    assign r_mag   = a_mag % divisor;
    assign quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem     = a_neg ? -r_mag : r_mag;

`ifdef MD_SCHED_MADD_EN
    assign acc = {hi_reg, lo_reg} + product;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        busy_next  = busy_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (launch_op) begin
                        op_next    = bus.op;
                        a_next     = bus.A;
                        b_next     = bus.B;
                        cnt_next   = start_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_next = RUN;
                        busy_next  = 1'b1;
                    end else if (bus.op == 3'd4) begin
                        hi_next = bus.A;
                    end else if (bus.op == 3'd5) begin
                        lo_next = bus.A;
                    end
                end
            end
            RUN: begin
                // New commands are ignored here; md_stall keeps the pipeline from issuing them.
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    if (op_is_div) begin
                        if (b_reg != 32'd0) begin
                            hi_next = rem;
                            lo_next = quot;
                        end
                    end
`ifdef MD_SCHED_MADD_EN
                    else if (op_reg[2]) begin
                        {hi_next, lo_next} = acc;
                    end
`endif
                    else begin
                        {hi_next, lo_next} = product;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy     = busy_reg;
    assign bus.md_stall = busy_reg | (bus.start & launch_op);
    assign bus.HI       = hi_reg;
    assign bus.LO       = lo_reg;
endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: expected HI/LO and busy length queued at issue, checked when busy falls.
module tb_md_sched;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_sched_if bus();
    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          mon_cnt = 0;
    logic        mon_prev = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    // Commit monitor: counts busy cycles and compares HI/LO when busy falls.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_cnt  = 0;
                mon_prev = 1'b0;
            end else begin
                if (bus.busy) begin
                    mon_cnt++;
                end else if (mon_prev) begin
                    if (sb.size() == 0) begin
                        check_val("spurious_commit", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        $display("commit: HI=%08h LO=%08h busy_cycles=%0d", bus.HI, bus.LO, mon_cnt);
                        check_val("commit_hi", bus.HI, e.hi);
                        check_val("commit_lo", bus.LO, e.lo);
                        check_val("busy_cycles", mon_cnt, e.cyc);
                    end
                    mon_cnt = 0;
                end
                mon_prev = bus.busy;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_stall);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        $display("issue: op=%0d A=%08h B=%08h", op, a, b);
        #1 check_val("md_stall_issue", {31'd0, bus.md_stall}, {31'd0, exp_stall});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Reference model for multi-cycle ops; computes the expected result and queues it.
    task automatic sched(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      q, r;
        exp_t        e;
        p = 64'd0;
        case (op)
            3'd0, 3'd6: p = longint'($signed(a)) * longint'($signed(b));
            3'd1, 3'd7: p = {32'd0, a} * {32'd0, b};
            3'd2: if (b != 32'd0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            3'd3: if (b != 32'd0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            default: ;
        endcase
        if (op == 3'd0 || op == 3'd1) {m_hi, m_lo} = p;
        if (op >= 3'd6) {m_hi, m_lo} = {m_hi, m_lo} + p;
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.cyc = (op == 3'd2 || op == 3'd3) ? 10 : 5;
        sb.push_back(e);
        issue(op, a, b, 1'b1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            #2 n++;
        end
        check_val("drain", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        repeat (2) @(negedge clk);
        check_val("reset_busy", {31'd0, bus.busy}, 32'd0);
        check_val("reset_stall", {31'd0, bus.md_stall}, 32'd0);
        check_val("reset_hi", bus.HI, 32'd0);
        check_val("reset_lo", bus.LO, 32'd0);
        #2 reset = 1'b0;

        // mthi: single-edge write, never busy
        m_hi = 32'h1234_5678;
        issue(3'd4, 32'h1234_5678, 32'd0, 1'b0);
        #1 check_val("mthi_hi", bus.HI, 32'h1234_5678);
        for (int k = 0; k < 3; k++) begin
            check_val("mthi_busy", {31'd0, bus.busy}, 32'd0);
            @(negedge clk);
            #1;
        end

        // mult with md_stall profile: 5 busy cycles then released
        sched(3'd0, 32'hFFFF_FFFF, 32'd2);
        for (int k = 1; k <= 6; k++) begin
            #1 check_val("md_stall_run", {31'd0, bus.md_stall}, (k <= 5) ? 32'd1 : 32'd0);
            if (k < 6) @(negedge clk);
        end
        wait_drain();

        sched(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_drain();
        sched(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_drain();
        sched(3'd3, 32'd7, 32'd0);
        wait_drain();
        sched(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_drain();

        // mtlo during RUN must be ignored
        sched(3'd0, 32'd3, 32'd4);
        #1 check_val("stall_overlap_a", {31'd0, bus.md_stall}, 32'd1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd5;
        bus.A     = 32'hDEAD_BEEF;
        #1 check_val("stall_overlap_b", {31'd0, bus.md_stall}, 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        #1 check_val("stall_overlap_c", {31'd0, bus.md_stall}, 32'd1);
        wait_drain();

        for (int i = 0; i < 6; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            rop = 3'($urandom_range(3, 0));
            ra  = $urandom;
            rb  = (i == 2) ? 32'd13 : $urandom;
            sched(rop, ra, rb);
            wait_drain();
        end

        // maddu: {HI,LO} = {0, FFFFFFFF} + 1*1
        m_hi = 32'd0;
        issue(3'd4, 32'd0, 32'd0, 1'b0);
        m_lo = 32'hFFFF_FFFF;
        issue(3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0);
`ifdef MD_SCHED_MADD_EN
        sched(3'd7, 32'd1, 32'd1);
        wait_drain();
        check_val("maddu_hi", bus.HI, 32'd1);
        check_val("maddu_lo", bus.LO, 32'd0);
`else
        issue(3'd7, 32'd1, 32'd1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            #1 check_val("maddu_noop_busy", {31'd0, bus.busy}, 32'd0);
            @(negedge clk);
        end
        check_val("maddu_noop_hi", bus.HI, m_hi);
        check_val("maddu_noop_lo", bus.LO, m_lo);
`endif

        // async reset in the middle of a div: immediate clear, no later commit
        issue(3'd2, 32'd100, 32'd7, 1'b1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst_mid_hi", bus.HI, 32'd0);
        check_val("rst_mid_lo", bus.LO, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (15) @(negedge clk);
        #1;
        check_val("rst_after_busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst_after_hi", bus.HI, m_hi);
        check_val("rst_after_lo", bus.LO, m_lo);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide scheduler for the 5-stage pipeline.
- Sits in EX beside the ALU and owns the HI/LO registers.
- Accepts mult/div/mthi/mtlo commands from EX, sequences a fixed-latency busy window, then commits results to HI/LO.
- Exports a stall request that the conflict/hazard unit uses to freeze IF/ID and bubble ID/EX for any D-stage mult/div/mfhi/mflo/mthi/mtlo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- start  input  1  EX-stage instruction is an HI/LO command this cycle
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu
- A  input  32  forwarded rs value (Mux_rsE)
- B  input  32  forwarded rt value (Mux_rtE)
- busy  output  1  registered; multi-cycle op in progress
- md_stall  output  1  combinational: busy | (start & op<=3)
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset (async, active-high) sets HI=0, LO=0, busy=0, counter=0, state IDLE. It takes effect immediately and aborts any in-flight op; no partial commit.
- States: IDLE and RUN.
- IDLE, start=1, op in {0..3}:
  - latch A and B and op
  - load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3)
  - go to RUN; busy=1 from the next cycle
- IDLE, start=1, op 4: HI<=A at this edge; no busy. Op 5 does the same for LO.
- RUN: counter decrements each edge. At the edge where counter==1:
  - commit HI/LO from latched operands
  - busy<=0, return to IDLE
  - busy is therefore high for exactly N cycles. HI/LO are visible in the cycle busy falls.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0]
  - multu: same, unsigned
  - div: LO=quotient, HI=remainder; signed, truncating toward zero, remainder takes the dividend's sign
  - divu: same, unsigned
- Divide by zero: the busy window runs normally; HI/LO are left unchanged at commit.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- start while RUN (any op): ignored, no state change. The hazard unit guarantees this cannot happen because md_stall covers it.
- HI/LO hold their value between commits; A/B changes during RUN do not affect the result.
- op 6/7 without the macro: treated as a no-op (no busy, HI/LO unchanged).

Optional Feature:
- Macro MD_SCHED_MADD_EN.
- When defined:
  - op 6 (madd) and op 7 (maddu) are multi-cycle ops using MULT_CYCLES
  - at commit, {HI,LO} <= {HI,LO} + product (signed for op 6, unsigned for op 7), modulo 2^64
  - {HI,LO} is sampled at commit, not at start
  - md_stall also covers op 6/7: busy | (start & (op<=3 | op>=6))
- When undefined: op 6/7 are no-ops and md_stall covers op<=3 only.

Test Plan:
- reset asserted mid-RUN of div -> busy=0, HI=0, LO=0 immediately, before the next edge; after release, no commit occurs.
- mult A=0xFFFFFFFF, B=2 -> busy high for 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE when busy falls. The same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 -> busy high for 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu A=7, B=0 -> 10 busy cycles; HI/LO unchanged.
- mthi A=0x12345678 -> HI=0x12345678 after 1 edge, busy never rises. Then mult start followed by start=1 op=5 during RUN -> LO is only the mult result; md_stall=1 throughout.
- md_stall: start=1 op=0 in IDLE -> md_stall=1 in the same cycle, stays 1 for 5 more cycles, then 0. start=1 op=4 -> md_stall=0.
- MD_SCHED_MADD_EN: with HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 -> after 5 busy cycles HI=1, LO=0. Without the macro, the same stimulus -> HI/LO unchanged and busy stays 0.
